hamming_stream_encoder: RTL and testbench

Byte-stream transmitter for the Hamming(7,4) link. It accepts 8-bit bytes on a valid/ready input and splits each byte into two nibbles, high nibble first. Each nibble goes out as a registered 7-bit codeword on a valid/ready output, in the bit ordering the on-chip Hamming decoder expects. It also has test-only single-bit error injection and a wrapping codeword counter for the demo harness.

---
 rtl/hamming_pkg.sv | 56 +++++
 rtl/hamming_encoder_core.sv | 21 ++
 rtl/hamming_stream_encoder.sv | 113 +++++++++++
 tb/tb_hamming_stream_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: position-to-index mapping, parity group masks,
// the encoder FSM state type and a single encode/syndrome definition for both link ends.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;

  // Hamming positions (1-based) of parity and data bits
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_D3 = 3;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D1 = 6;
  localparam int unsigned POS_D0 = 7;

  // Code index of Hamming position p is CODE_W - p (position 1 sits in the MSB)
  localparam int unsigned IDX_P1 = CODE_W - POS_P1;
  localparam int unsigned IDX_P2 = CODE_W - POS_P2;
  localparam int unsigned IDX_D3 = CODE_W - POS_D3;
  localparam int unsigned IDX_P4 = CODE_W - POS_P4;
  localparam int unsigned IDX_D2 = CODE_W - POS_D2;
  localparam int unsigned IDX_D1 = CODE_W - POS_D1;
  localparam int unsigned IDX_D0 = CODE_W - POS_D0;

  // Positions covered by each syndrome bit, expressed as code-index masks
  localparam logic [CODE_W-1:0] MASK_S1 = 7'b1010101;  // positions 1,3,5,7
  localparam logic [CODE_W-1:0] MASK_S2 = 7'b0110011;  // positions 2,3,6,7
  localparam logic [CODE_W-1:0] MASK_S4 = 7'b0001111;  // positions 4,5,6,7

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_HI,
    ST_SEND_LO
  } tx_state_e;

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[IDX_D3] = d[3];
    c[IDX_D2] = d[2];
    c[IDX_D1] = d[1];
    c[IDX_D0] = d[0];
    // Parity slots are still zero here, so each group XOR yields even parity
    c[IDX_P1] = ^(c & MASK_S1);
    c[IDX_P2] = ^(c & MASK_S2);
    c[IDX_P4] = ^(c & MASK_S4);
    return c;
  endfunction

  // Syndrome value equals the Hamming position of a single flipped bit (0 = clean)
  function automatic logic [2:0] hamming_syndrome(input logic [CODE_W-1:0] c);
    return {^(c & MASK_S4), ^(c & MASK_S2), ^(c & MASK_S1)};
  endfunction

endpackage

// File: rtl/hamming_encoder_core.sv
// Combinational nibble encoder with optional single-bit error injection at a
// Hamming position (1..7); position 0 leaves the codeword untouched.
module hamming_encoder_core
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] nibble,
  input  logic [2:0]        inj_pos,
  output logic [CODE_W-1:0] code
);

  logic [CODE_W-1:0] flip_mask;

  always_comb begin
    flip_mask = '0;
    if (inj_pos != 3'd0) begin
      flip_mask = 7'b1000000 >> (inj_pos - 3'd1);
    end
    code = hamming_encode(nibble) ^ flip_mask;
  end

endmodule

// File: rtl/hamming_stream_encoder.sv
// Byte-stream Hamming(7,4) transmitter: each accepted byte leaves as two registered
// codewords (high nibble first) on a valid/ready output, with a wrapping handshake counter.
module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic [2:0]        in_inj_pos,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cw_count
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] lo_nib_q, lo_nib_d;
  logic [2:0]        inj_q, inj_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CODE_W-1:0] enc_new_hi;
  logic [CODE_W-1:0] enc_held_lo;
  logic              in_ready_c;
  logic              out_hs;

  // High nibble comes straight from the input byte; low nibble from the byte register
  hamming_encoder_core u_enc_hi (
    .nibble  (in_data[7:4]),
    .inj_pos (in_inj_pos),
    .code    (enc_new_hi)
  );

  hamming_encoder_core u_enc_lo (
    .nibble  (lo_nib_q),
    .inj_pos (inj_q),
    .code    (enc_held_lo)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lo_nib_d   = lo_nib_q;
    inj_d      = inj_q;
    code_d     = code_q;
    in_ready_c = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          lo_nib_d = in_data[3:0];
          inj_d    = in_inj_pos;
          code_d   = enc_new_hi;
          state_d  = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        out_valid = 1'b1;
        if (out_ready) begin
          code_d  = enc_held_lo;
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        out_valid  = 1'b1;
        in_ready_c = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            lo_nib_d = in_data[3:0];
            inj_d    = in_inj_pos;
            code_d   = enc_new_hi;
            state_d  = ST_SEND_HI;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_hs = out_valid & out_ready;
  assign cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, out_hs};

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lo_nib_q <= '0;
      inj_q    <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lo_nib_q <= lo_nib_d;
      inj_q    <= inj_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
    end
  end

  // The FSM sits in IDLE during reset; gate ready so no byte looks accepted then
  assign in_ready = in_ready_c & rst_n;
  assign out_code = code_q;
  assign cw_count = cnt_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Self-checking bench: directed and random byte traffic compared cycle by cycle
// against a transaction-level queue model with a position-based Hamming reference.
module tb_hamming_stream_encoder;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [7:0]       in_data;
  logic [2:0]       in_inj_pos;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       out_code;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cw_count;

  hamming_stream_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_inj_pos (in_inj_pos),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cw_count   (cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] code;
    logic [3:0] nib;
    logic [2:0] inj;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               checks;
  int               failures;

  // Reference encoder straight from the Hamming definition: parity at powers of two
  // covers every position sharing that bit; position p lands at code index 7-p.
  function automatic logic [6:0] ref_enc(input logic [3:0] d, input logic [2:0] inj);
    logic [7:0] bits;
    logic [6:0] c;
    bits    = '0;
    bits[3] = d[3];
    bits[5] = d[2];
    bits[6] = d[1];
    bits[7] = d[0];
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int q = 1; q <= 7; q++) begin
        if (q != p && (q & p) != 0) bits[p] = bits[p] ^ bits[q];
      end
    end
    if (inj != 3'd0) bits[inj] = ~bits[inj];
    for (int p = 1; p <= 7; p++) c[7-p] = bits[p];
    return c;
  endfunction

  // Reference decoder: syndrome is the XOR of the positions of all set bits
  function automatic logic [4:0] ref_dec(input logic [6:0] c);
    int         s;
    logic [6:0] fixed;
    s = 0;
    for (int p = 1; p <= 7; p++) if (c[7-p]) s = s ^ p;
    fixed = c;
    if (s != 0) fixed[7-s] = ~fixed[7-s];
    return {(s != 0), fixed[7-3], fixed[7-5], fixed[7-6], fixed[7-7]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] inj,
                      input logic ordy, input string tag);
    logic       exp_valid;
    logic       exp_ready;
    logic [4:0] dec;
    in_valid   = v;
    in_data    = d;
    in_inj_pos = inj;
    out_ready  = ordy;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".cw_count"}, 32'(cw_count), 32'(exp_cnt));
    if (exp_valid) begin
      check({tag, ".out_code"}, 32'(out_code), 32'(exp_q[0].code));
      if (ordy) begin
        dec = ref_dec(out_code);
        check({tag, ".dec_data"}, 32'(dec[3:0]), 32'(exp_q[0].nib));
        check({tag, ".dec_err"}, 32'(dec[4]), 32'(exp_q[0].inj != 3'd0));
        void'(exp_q.pop_front());
        exp_cnt++;
      end
    end
    if (exp_ready && v) begin
      exp_q.push_back('{code: ref_enc(d[7:4], inj), nib: d[7:4], inj: inj});
      exp_q.push_back('{code: ref_enc(d[3:0], inj), nib: d[3:0], inj: inj});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_code"}, 32'(out_code), 32'd0);
    check({tag, ".cw_count"}, 32'(cw_count), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_cnt    = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_inj_pos = '0;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // 0xA5, clean, free-flowing output
    step(1'b1, 8'hA5, 3'd0, 1'b1, "a5_acc");
    check("a5_hi_literal", 32'(out_code), 32'h5A);
    step(1'b0, 8'h00, 3'd0, 1'b1, "a5_hi");
    check("a5_lo_literal", 32'(out_code), 32'h25);
    step(1'b0, 8'h00, 3'd0, 1'b1, "a5_lo");
    check("a5_count_literal", 32'(cw_count), 32'd2);
    step(1'b0, 8'h00, 3'd0, 1'b1, "a5_idle");

    // Back-to-back 0x0F then 0xF0 with in_valid held
    step(1'b1, 8'h0F, 3'd0, 1'b1, "b2b_0");
    step(1'b1, 8'hF0, 3'd0, 1'b1, "b2b_1");
    step(1'b1, 8'hF0, 3'd0, 1'b1, "b2b_2");
    step(1'b0, 8'h00, 3'd0, 1'b1, "b2b_3");
    step(1'b0, 8'h00, 3'd0, 1'b1, "b2b_4");
    step(1'b0, 8'h00, 3'd0, 1'b1, "b2b_5");

    // Injection at position 3 on both codewords
    step(1'b1, 8'hA5, 3'd3, 1'b1, "inj_acc");
    check("inj_hi_literal", 32'(out_code), 32'h4A);
    step(1'b0, 8'h00, 3'd0, 1'b1, "inj_hi");
    check("inj_lo_literal", 32'(out_code), 32'h35);
    step(1'b0, 8'h00, 3'd0, 1'b1, "inj_lo");

    // Backpressure: hold out_ready low for 5 cycles, stray in_valid must be ignored
    step(1'b1, 8'h3C, 3'd0, 1'b0, "hold_acc");
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 3'd5, 1'b0, "hold");
    step(1'b0, 8'h00, 3'd0, 1'b1, "hold_rel_hi");
    step(1'b0, 8'h00, 3'd0, 1'b0, "hold_lo_stall");
    step(1'b0, 8'h00, 3'd0, 1'b1, "hold_rel_lo");
    step(1'b0, 8'h00, 3'd0, 1'b1, "hold_idle");

    // Reset while in SEND_LO discards the pending codeword
    step(1'b1, 8'hC3, 3'd2, 1'b1, "rst_acc");
    step(1'b0, 8'h00, 3'd0, 1'b1, "rst_hi");
    do_reset("rst_mid");
    step(1'b0, 8'h00, 3'd0, 1'b1, "rst_idle");
    step(1'b1, 8'h55, 3'd0, 1'b1, "post_acc");
    check("post_hi_literal", 32'(out_code), 32'h25);
    step(1'b0, 8'h00, 3'd0, 1'b1, "post_hi");
    check("post_lo_literal", 32'(out_code), 32'h25);
    step(1'b0, 8'h00, 3'd0, 1'b1, "post_lo");

    // Random traffic with random backpressure and injection
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 1) ? $urandom_range(1, 7) : 0),
           1'($urandom_range(0, 3) != 0), "rand");
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 3'd0, 1'b1, "drain");

    // Counter wrap: 128 bytes back-to-back from a fresh reset
    do_reset("wrap_rst");
    for (int i = 0; i < 257; i++) begin
      if (i == 256) check("wrap_pre", 32'(cw_count), 32'hFF);
      step(1'(i < 255), 8'($urandom), 3'd0, 1'b1, "wrap");
    end
    check("wrap_post", 32'(cw_count), 32'h00);
    step(1'b0, 8'h00, 3'd0, 1'b1, "wrap_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
